// File: rtl/ddr3_seq_pkg.sv
// Shared types and default widths for the DDR3 burst sequencer.
package ddr3_seq_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_WRITE     = 2'd2,
        ST_READ      = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ddr3_beat_counter.sv
// Per-beat word address generator plus remaining-beats down-counter.
// Loaded at command acceptance, stepped once per completed beat.
module ddr3_beat_counter #(
    parameter int ADDR_W = 27,
    parameter int LEN_W  = 16
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;

    // Address wraps naturally modulo 2^ADDR_W; the counter holds beats-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_addr;
            r_remaining <= i_len;
        end else if (i_step) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == '0);

endmodule

// File: rtl/ddr3_burst_sequencer.sv
// Burst command front-end for slowDDR3: turns {addr, len, dir} commands
// into per-beat sysIO transfers with zero-latency data passthrough.
module ddr3_burst_sequencer
    import ddr3_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int LEN_W  = DEF_LEN_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ddr_address,
    output logic [SEL_W-1:0]  ddr_sel,
    output logic              ddr_wr_valid,
    input  logic              ddr_wr_ready,
    output logic [DATA_W-1:0] ddr_wr_payload,
    output logic              ddr_rd_ready,
    input  logic              ddr_rd_valid,
    input  logic [DATA_W-1:0] ddr_rd_payload,
    input  logic              ddr_init_fin
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [SEL_W-1:0]  r_sel;
    logic              r_done;
    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    // cmd_ready is held low during the done cycle so the two never overlap.
    assign w_accept = (r_state == ST_IDLE) && !r_done && cmd_valid;
    assign w_beat   = ((r_state == ST_WRITE) && wdata_valid && ddr_wr_ready) ||
                      ((r_state == ST_READ)  && ddr_rd_valid && rdata_ready);

    ddr3_beat_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_addr (cmd_addr),
        .i_len  (cmd_len),
        .i_step (w_beat),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // State register; reset aborts any burst back to waiting for init.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_WAIT_INIT;
        else       r_state <= w_next_state;
    end

    // Byte select latched per command; done marks the beat after the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_accept) r_sel <= cmd_sel;
            r_done <= w_beat && w_last;
        end
    end

    // Next-state logic; init_fin is sticky because WAIT_INIT is never re-entered.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_INIT: if (ddr_init_fin) w_next_state = ST_IDLE;
            ST_IDLE:      if (w_accept)     w_next_state = cmd_write ? ST_WRITE : ST_READ;
            ST_WRITE,
            ST_READ:      if (w_beat && w_last) w_next_state = ST_IDLE;
            default:      w_next_state = ST_WAIT_INIT;
        endcase
    end

    // Output decode: handshakes are pure passthrough gated by state.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        cmd_ready      = 1'b0;
        busy           = 1'b0;
        wdata_ready    = 1'b0;
        ddr_wr_valid   = 1'b0;
        ddr_wr_payload = '0;
        ddr_rd_ready   = 1'b0;
        rdata_valid    = 1'b0;
        rdata          = '0;
        rdata_last     = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = !r_done;
            ST_WRITE: begin
                busy           = 1'b1;
                ddr_wr_valid   = wdata_valid;
                ddr_wr_payload = wdata;
                wdata_ready    = ddr_wr_ready;
            end
            ST_READ: begin
                busy         = 1'b1;
                ddr_rd_ready = rdata_ready;
                rdata_valid  = ddr_rd_valid;
                rdata        = ddr_rd_payload;
                rdata_last   = w_last;
            end
            default: ;
        endcase
    end

    assign done        = r_done;
    assign ddr_address = w_addr;
    assign ddr_sel     = r_sel;

endmodule

// File: tb/tb_ddr3_burst_sequencer.sv
// Self-checking bench for ddr3_burst_sequencer: a cycle-by-cycle vector
// table plus hand-written sequences for long, wrapping, queued and
// reset-aborted bursts against a small sysIO memory model.
module tb_ddr3_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [26:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [1:0]  cmd_sel;
    logic        wdata_valid, wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [15:0] rdata;
    logic        busy, done;
    logic [26:0] ddr_address;
    logic [1:0]  ddr_sel;
    logic        ddr_wr_valid, ddr_wr_ready;
    logic [15:0] ddr_wr_payload;
    logic        ddr_rd_ready, ddr_rd_valid;
    logic [15:0] ddr_rd_payload;
    logic        ddr_init_fin;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] mem [logic [26:0]];

    typedef struct packed {
        logic        cmd_valid;
        logic        cmd_write;
        logic [26:0] cmd_addr;
        logic [15:0] cmd_len;
        logic [1:0]  cmd_sel;
        logic        wdata_valid;
        logic [15:0] wdata;
        logic        ddr_wr_ready;
        logic        ddr_rd_valid;
        logic [15:0] ddr_rd_payload;
        logic        rdata_ready;
    } in_t;

    typedef struct packed {
        logic        cmd_ready;
        logic        busy;
        logic        done;
        logic        ddr_wr_valid;
        logic        wdata_ready;
        logic [15:0] ddr_wr_payload;
        logic        ddr_rd_ready;
        logic        rdata_valid;
        logic [15:0] rdata;
        logic        rdata_last;
        logic [26:0] ddr_address;
        logic [1:0]  ddr_sel;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t exp;
    } vec_t;

    vec_t vecs [12];

    ddr3_burst_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_sel        (cmd_sel),
        .wdata_valid    (wdata_valid),
        .wdata_ready    (wdata_ready),
        .wdata          (wdata),
        .rdata_valid    (rdata_valid),
        .rdata_ready    (rdata_ready),
        .rdata          (rdata),
        .rdata_last     (rdata_last),
        .busy           (busy),
        .done           (done),
        .ddr_address    (ddr_address),
        .ddr_sel        (ddr_sel),
        .ddr_wr_valid   (ddr_wr_valid),
        .ddr_wr_ready   (ddr_wr_ready),
        .ddr_wr_payload (ddr_wr_payload),
        .ddr_rd_ready   (ddr_rd_ready),
        .ddr_rd_valid   (ddr_rd_valid),
        .ddr_rd_payload (ddr_rd_payload),
        .ddr_init_fin   (ddr_init_fin)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within 1 ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t sample_outputs();
        exp_t s;
        s = '{cmd_ready, busy, done, ddr_wr_valid, wdata_ready, ddr_wr_payload,
              ddr_rd_ready, rdata_valid, rdata, rdata_last, ddr_address, ddr_sel};
        return s;
    endfunction

    task automatic clear_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
        wdata_valid = 1'b0; wdata = '0; ddr_wr_ready = 1'b0;
        ddr_rd_valid = 1'b0; ddr_rd_payload = '0; rdata_ready = 1'b0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [26:0] a, input logic [15:0] len,
                             input logic [1:0] sel);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_sel = sel;
        #1;
        while (!cmd_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [26:0] a, input int n, input logic [15:0] base, input bit gaps);
        int k = 0;
        int cyc = 0;
        logic [26:0] exp_a;
        while (k < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            wdata_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata        = base + k[15:0];
            ddr_wr_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (ddr_wr_valid && ddr_wr_ready) begin
                exp_a = a + k[26:0];
                check("wr_addr", ddr_address, exp_a);
                check("wr_payload", ddr_wr_payload, base + k[15:0]);
                check("wdata_ready", wdata_ready, 1'b1);
                mem[ddr_address] = ddr_wr_payload;
                k++;
            end
            cyc++;
        end
        check("wr_beat_count", k, n);
        @(negedge clk);
        wdata_valid = 1'b0; ddr_wr_ready = 1'b0;
        #1;
        check("wr_done_pulse", {done, busy, cmd_ready}, 3'b100);
    endtask

    task automatic run_read(input logic [26:0] a, input int n, input logic [15:0] base, input bit gaps);
        int k = 0;
        int cyc = 0;
        logic [26:0] exp_a;
        while (k < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            ddr_rd_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ddr_rd_payload = mem.exists(ddr_address) ? mem[ddr_address] : 16'hDEAD;
            rdata_ready    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (rdata_valid && rdata_ready) begin
                exp_a = a + k[26:0];
                check("rd_addr", ddr_address, exp_a);
                check("rd_data", rdata, base + k[15:0]);
                check("rd_last", rdata_last, (k == n - 1));
                check("ddr_rd_ready", ddr_rd_ready, 1'b1);
                k++;
            end
            cyc++;
        end
        check("rd_beat_count", k, n);
        @(negedge clk);
        ddr_rd_valid = 1'b0; rdata_ready = 1'b0;
        #1;
        check("rd_done_pulse", {done, busy, cmd_ready}, 3'b100);
    endtask

    initial begin
        int bad;
        exp_t act;

        // Cycle table: write 0x100 len 0 with ready after 3 stalls, then a
        // 2-beat read that wraps from 0x7FFFFFF to 0.
        vecs[0]  = '{in: '{1'b1, 1'b1, 27'h100, 16'd0, 2'd3, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0},
                     exp: '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h0, 2'd0}};
        vecs[1]  = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0},
                     exp: '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 27'h100, 2'd3}};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0},
                     exp: '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 27'h100, 2'd3}};
        vecs[5]  = '{in: '{1'b1, 1'b0, 27'h7FFFFFF, 16'd1, 2'd1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0},
                     exp: '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h101, 2'd3}};
        vecs[6]  = '{in: vecs[5].in,
                     exp: '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h101, 2'd3}};
        vecs[7]  = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1111, 1'b0},
                     exp: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1111, 1'b0, 27'h7FFFFFF, 2'd1}};
        vecs[8]  = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1111, 1'b1},
                     exp: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1111, 1'b0, 27'h7FFFFFF, 2'd1}};
        vecs[9]  = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2222, 1'b1},
                     exp: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h2222, 1'b1, 27'h0, 2'd1}};
        vecs[10] = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h3333, 1'b1},
                     exp: '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h1, 2'd1}};
        vecs[11] = '{in: '{1'b0, 1'b0, 27'h0, 16'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0},
                     exp: '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h1, 2'd1}};

        // Reset state
        clear_inputs();
        reset = 1'b1; ddr_init_fin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", sample_outputs(), '0);

        // Hold init_fin low with every request asserted: nothing may move
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 27'h55; wdata_valid = 1'b1;
        ddr_wr_ready = 1'b1; ddr_rd_valid = 1'b1; rdata_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cmd_ready || busy || done || ddr_wr_valid || ddr_rd_ready || rdata_valid || wdata_ready)
                bad++;
        end
        check("wait_init_quiet", bad, 0);
        @(negedge clk);
        clear_inputs();
        ddr_init_fin = 1'b1;
        #1;
        check("init_ready_not_yet", cmd_ready, 1'b0);
        @(negedge clk);
        ddr_init_fin = 1'b0;
        #1;
        check("init_ready_after", cmd_ready, 1'b1);

        // Table-driven cycle vectors (init_fin stays low: sticky)
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            {cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_sel, wdata_valid, wdata,
             ddr_wr_ready, ddr_rd_valid, ddr_rd_payload, rdata_ready} = vecs[i].in;
            #1;
            act = sample_outputs();
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end
        @(negedge clk);
        clear_inputs();

        // Long gapped write then gapped read of the same range
        issue_cmd(1'b1, 27'h0, 16'd511, 2'd3);
        run_write(27'h0, 512, 16'h0, 1'b1);
        issue_cmd(1'b0, 27'h0, 16'd511, 2'd3);
        run_read(27'h0, 512, 16'h0, 1'b1);

        // Address wrap at the top of the word space
        issue_cmd(1'b1, 27'h7FFFFFE, 16'd3, 2'd2);
        run_write(27'h7FFFFFE, 4, 16'h0050, 1'b0);
        issue_cmd(1'b0, 27'h7FFFFFE, 16'd3, 2'd2);
        run_read(27'h7FFFFFE, 4, 16'h0050, 1'b0);

        // Read command offered during an active write waits for done+1
        mem[27'h300] = 16'h0A00;
        mem[27'h301] = 16'h0A01;
        issue_cmd(1'b1, 27'h200, 16'd3, 2'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h300; cmd_len = 16'd1; cmd_sel = 2'd2;
        wdata_valid = 1'b1; ddr_wr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (c < 5) check("queued_hold", cmd_ready, 1'b0);
            else       check("queued_ready", cmd_ready, 1'b1);
            if (c == 4) check("queued_done", done, 1'b1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; wdata_valid = 1'b0; ddr_wr_ready = 1'b0;
        @(negedge clk); #1;
        check("queued_start", {busy, ddr_address, ddr_sel}, {1'b1, 27'h300, 2'd2});
        run_read(27'h300, 2, 16'h0A00, 1'b0);

        // Reset at beat 5 of an 8-beat read
        for (int i = 0; i < 8; i++) mem[27'h40 + i[26:0]] = 16'hC000 + i[15:0];
        issue_cmd(1'b0, 27'h40, 16'd7, 2'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ddr_rd_valid = 1'b1; ddr_rd_payload = mem[ddr_address]; rdata_ready = 1'b1;
        end
        @(negedge clk);
        ddr_rd_payload = mem[ddr_address];
        #1;
        check("abort_beat5", {rdata_valid, ddr_address}, {1'b1, 27'h45});
        reset = 1'b1;
        #1;
        check("abort_same_cycle", {ddr_rd_ready, rdata_valid, busy, done, cmd_ready, ddr_address},
              {5'b00000, 27'h0});
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h50;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (cmd_ready || busy || ddr_rd_ready || rdata_valid || ddr_wr_valid) bad++;
        end
        check("no_xfer_before_reinit", bad, 0);
        @(negedge clk);
        clear_inputs();
        ddr_init_fin = 1'b1;
        @(negedge clk); #1;
        check("reinit_ready", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr3_burst_sequencer.md
Name: ddr3_burst_sequencer

Overview:
- Upstream front-end for slowDDR3. Accepts burst commands (start address, beat count, direction) and converts them into per-beat transfers on slowDDR3's sysIO word interface.
- Write data comes in on a stream port; read data goes out on a stream port with a last-beat marker.
- Generates the per-beat address, so clients never drive per-word addresses.

Parameters:
- ADDR_W, 27, word address width; matches sysIO_address.
- DATA_W, 16, word width; matches sysIO payloads.
- SEL_W, 2, byte-select width; matches sysIO_sel.
- LEN_W, 16, burst length field width. Length is encoded as beats-1.

Ports:
- clk  in  1  system clock; same clock as slowDDR3.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  LEN_W  beats-1.
- cmd_sel  in  SEL_W  byte select, held for the whole burst.
- wdata_valid  in  1  write word offered.
- wdata_ready  out  1  write word consumed.
- wdata  in  DATA_W  write word.
- rdata_valid  out  1  read word available.
- rdata_ready  in  1  consumer accepts read word.
- rdata  out  DATA_W  read word.
- rdata_last  out  1  final beat of the current read burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final beat of any burst.
- ddr_address  out  ADDR_W  to sysIO_address.
- ddr_sel  out  SEL_W  to sysIO_sel.
- ddr_wr_valid  out  1  to sysIO_dataWr_valid.
- ddr_wr_ready  in  1  from sysIO_dataWr_ready.
- ddr_wr_payload  out  DATA_W  to sysIO_dataWr_payload.
- ddr_rd_ready  out  1  to sysIO_dataRd_ready.
- ddr_rd_valid  in  1  from sysIO_dataRd_valid.
- ddr_rd_payload  in  DATA_W  from sysIO_dataRd_payload.
- ddr_init_fin  in  1  from sysIO_initFin.

Behaviour:
- Reset values:
  - state=WAIT_INIT; address register, sel register and beat counter = 0.
  - All outputs are 0: cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, done, ddr_wr_valid, ddr_rd_ready, ddr_address, ddr_sel.
- WAIT_INIT:
  - Moves to IDLE on the first cycle ddr_init_fin=1.
  - init_fin is sticky from then on; a later deassertion is ignored.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On cmd_valid: register cmd_addr, cmd_sel and cmd_len into the remaining counter, then go to WRITE or READ per cmd_write.
  - busy=1 from the cycle after acceptance until the cycle after the final beat.
- WRITE (zero-latency passthrough):
  - ddr_wr_valid=wdata_valid; ddr_wr_payload=wdata; wdata_ready=ddr_wr_ready.
  - A beat occurs when ddr_wr_valid&ddr_wr_ready. On each beat: address+1, remaining-1.
  - ddr_wr_valid, ddr_wr_payload and ddr_address stay stable while stalled.
  - Beat with remaining==0: done=1 next cycle, return to IDLE, ddr_wr_valid drops.
- READ (passthrough):
  - ddr_rd_ready=rdata_ready; rdata_valid=ddr_rd_valid; rdata=ddr_rd_payload; rdata_last=(remaining==0).
  - A beat occurs when ddr_rd_valid&ddr_rd_ready; advance as in WRITE.
  - Outside READ: ddr_rd_ready=0 and rdata_valid=0.
- ddr_address=address register; ddr_sel=sel register. Both are constant between beats.
- Address arithmetic is modulo 2^ADDR_W: 0x7FFFFFF+1 -> 0x0000000. A burst may wrap.
- cmd_len=0 means exactly one beat. Max burst is 2^LEN_W beats.
- A command offered during a burst waits; cmd_ready=0 outside IDLE. The command is never lost or reordered.
- done and cmd_ready can never be 1 in the same cycle; done fires in the cycle IDLE is re-entered, so cmd_ready rises one cycle after done.
- Reset mid-burst: immediate abort to WAIT_INIT, all outputs 0. The remainder of the burst is discarded, and init_fin must be observed again.

Decomposition:
- Package ddr3_seq_pkg: state enum (WAIT_INIT, IDLE, WRITE, READ) and default width constants (27/16/2/16).
- Sub-module ddr3_beat_counter: address incrementer plus remaining-beats down-counter with load/step/last outputs. Shared by the WRITE and READ paths.

Test Plan:
- Hold ddr_init_fin=0 for 50 cycles while cmd_valid=1 -> cmd_ready stays 0 and no ddr_* strobes. Raise init_fin -> cmd_ready=1 next cycle.
- Write addr=0x100, len=0, wdata=0xBEEF, ddr_wr_ready pulsed after 3 cycles -> one beat at ddr_address=0x100 with payload 0xBEEF, done pulse, busy low after.
- Write addr=0, len=65535, wdata=beat index, wdata_valid randomly gapped -> 65536 beats, addresses 0..0xFFFF in order, no duplicate or dropped payload. Then read the same range with random rdata_ready stalls against the DDR3 model -> rdata equals index, rdata_last only on beat 65535.
- Write addr=0x7FFFFFE, len=3 -> ddr_address sequence 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
- Offer a read command while a write burst is active -> cmd_ready=0 until one cycle after done; read starts at its own cmd_addr.
- Assert reset at beat 5 of an 8-beat read -> same cycle: ddr_rd_ready=0, rdata_valid=0, busy=0. After release, no transfers occur until init_fin is seen again.
